rf_wb_scheduler: RTL and testbench

Write-port scheduler and hazard scoreboard in front of the single-write-port register file. Arbitrates two writeback sources onto the one write port: source 0 is ALU/EX writeback and source 1 is load/MEM writeback. Tracks registers with an outstanding write so decode can stall operand reads. Sits between the EX/MEM writeback stages and the register file, with a busy-query side port to decode.

---
 rtl/rf_wb_scheduler_pkg.sv | 21 ++
 rtl/rf_wb_scheduler_if.sv | 44 ++++
 rtl/rf_scoreboard.sv | 54 +++++
 rtl/rf_wb_scheduler.sv | 87 ++++++++
 tb/tb_rf_wb_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler: bus widths,
// enable polarities and the writeback source encoding.
package rf_wb_scheduler_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam int   RegAddrBus  = 5;
    localparam int   RegBus      = 32;
    localparam int   RegNum      = 32;
    localparam int   WbSrcNum    = 2;

    typedef enum logic {
        SRC_ALU  = 1'b0,
        SRC_LOAD = 1'b1
    } wb_src_e;

    function automatic wb_src_e other_src(input wb_src_e src);
        return (src == SRC_ALU) ? SRC_LOAD : SRC_ALU;
    endfunction

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Writeback request, regfile write port, issue and operand-query signals
// between the pipeline (master) and the writeback scheduler (slave).
interface rf_wb_scheduler_if
    import rf_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) ();

    logic              s0_valid;
    logic              s0_ready;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_data;
    logic              s1_valid;
    logic              s1_ready;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              wstall;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              flush;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              busy1;
    logic              busy2;

    modport master (
        output s0_valid, s0_addr, s0_data,
        output s1_valid, s1_addr, s1_data,
        output wstall, iss_valid, iss_addr, flush, chk_addr1, chk_addr2,
        input  s0_ready, s1_ready, we, waddr, wdata, busy1, busy2
    );

    modport slave (
        input  s0_valid, s0_addr, s0_data,
        input  s1_valid, s1_addr, s1_data,
        input  wstall, iss_valid, iss_addr, flush, chk_addr1, chk_addr2,
        output s0_ready, s1_ready, we, waddr, wdata, busy1, busy2
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on
// issue, cleared on regfile commit, with two write-through operand queries.
module rf_scoreboard
    import rf_wb_scheduler_pkg::*;
#(
    parameter int ADDR_W = RegAddrBus,
    parameter int NREG   = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              busy1,
    output logic              busy2
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            clr_hit;

    assign clr_hit = (clr_en == WriteEnable);

    // Priority: flush over set, set over clear on the same register.
    always_comb begin
        busy_next = busy;
        if (clr_hit) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_next[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // A register committing this cycle reads through the regfile, so it is not busy.
    assign busy1 = (chk_addr1 != '0) & busy[chk_addr1] & ~(clr_hit & (clr_addr == chk_addr1));
    assign busy2 = (chk_addr2 != '0) & busy[chk_addr2] & ~(clr_hit & (clr_addr == chk_addr2));

endmodule

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter of ALU and load writebacks onto the single regfile write
// port through a one-entry output slot, plus the pending-write scoreboard.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus,
    parameter int NREG   = RegNum
) (
    input logic              clk,
    input logic              rst,
    rf_wb_scheduler_if.slave bus
);

    logic                slot_valid;
    logic [ADDR_W-1:0]   slot_addr;
    logic [DATA_W-1:0]   slot_data;
    wb_src_e             rr_ptr;
    logic                we_int;
    logic                can_accept;
    logic [WbSrcNum-1:0] grant;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    always_comb begin
        we_int     = slot_valid & ~bus.wstall;
        can_accept = ~slot_valid | ~bus.wstall;
        grant      = '0;
        if (can_accept && !rst) begin
            if (bus.s0_valid && (!bus.s1_valid || rr_ptr == SRC_ALU)) begin
                grant[SRC_ALU] = 1'b1;
            end else if (bus.s1_valid) begin
                grant[SRC_LOAD] = 1'b1;
            end
        end
        sel_addr = grant[SRC_LOAD] ? bus.s1_addr : bus.s0_addr;
        sel_data = grant[SRC_LOAD] ? bus.s1_data : bus.s0_data;
    end

    // A grant is only possible when the slot is empty or draining, so a
    // grant to r0 simply leaves the slot empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
            rr_ptr     <= SRC_ALU;
        end else begin
            if (|grant) begin
                rr_ptr <= other_src(grant[SRC_LOAD] ? SRC_LOAD : SRC_ALU);
                if (sel_addr != '0) begin
                    slot_valid <= 1'b1;
                    slot_addr  <= sel_addr;
                    slot_data  <= sel_data;
                end else begin
                    slot_valid <= 1'b0;
                end
            end else if (we_int) begin
                slot_valid <= 1'b0;
            end
        end
    end

    assign bus.s0_ready = grant[SRC_ALU];
    assign bus.s1_ready = grant[SRC_LOAD];
    assign bus.we       = we_int;
    assign bus.waddr    = slot_addr;
    assign bus.wdata    = slot_data;

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (bus.iss_valid),
        .set_addr  (bus.iss_addr),
        .clr_en    (we_int),
        .clr_addr  (slot_addr),
        .flush     (bus.flush),
        .chk_addr1 (bus.chk_addr1),
        .chk_addr2 (bus.chk_addr2),
        .busy1     (bus.busy1),
        .busy2     (bus.busy2)
    );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration order, stall back-pressure,
// scoreboard set/clear/flush, r0 requests and mid-operation reset.
module tb_rf_wb_scheduler;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    rf_wb_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_wb_scheduler #(
        .DATA_W (32),
        .ADDR_W (5),
        .NREG   (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd3; bus.s0_data = 32'h11;
        bus.s1_valid = 1'b1; bus.s1_addr = 5'd5; bus.s1_data = 32'h22;
        bus.wstall = 1'b0; bus.iss_valid = 1'b0; bus.iss_addr = '0;
        bus.flush = 1'b0; bus.chk_addr1 = 5'd3; bus.chk_addr2 = 5'd0;
        #2;
        chk("rst_s0_ready", bus.s0_ready, 0);
        chk("rst_s1_ready", bus.s1_ready, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_busy1", bus.busy1, 0);
        nxt(); nxt();
        rst = 1'b0;
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;

        // Issue r3, then ALU writeback of r3.
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
        #1 chk("iss3_legal", bus.busy1, 0);
        nxt();
        bus.iss_valid = 1'b0;
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd3; bus.s0_data = 32'h11;
        #1;
        chk("r3_busy", bus.busy1, 1);
        chk("r3_s0_ready", bus.s0_ready, 1);
        chk("r3_s1_ready", bus.s1_ready, 0);
        chk("r3_we_pre", bus.we, 0);
        nxt();
        bus.s0_valid = 1'b0;
        #1;
        chk("r3_we", bus.we, 1);
        chk("r3_waddr", bus.waddr, 3);
        chk("r3_wdata", bus.wdata, 32'h11);
        chk("r3_busy_wt", bus.busy1, 0);
        nxt();
        // r0 load request: consumed, never written; pointer returns to ALU.
        bus.s1_valid = 1'b1; bus.s1_addr = 5'd0; bus.s1_data = 32'h55;
        #1;
        chk("r3_cleared", bus.busy1, 0);
        chk("r3_we_done", bus.we, 0);
        chk("r0_s1_ready", bus.s1_ready, 1);
        chk("r0_s0_ready", bus.s0_ready, 0);
        nxt();
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd4; bus.s0_data = 32'hA;
        bus.s1_valid = 1'b1; bus.s1_addr = 5'd5; bus.s1_data = 32'hB;
        #1;
        chk("r0_no_we", bus.we, 0);
        chk("rr_s0_first", bus.s0_ready, 1);
        chk("rr_s1_wait", bus.s1_ready, 0);
        nxt();
        bus.s0_addr = 5'd6; bus.s0_data = 32'hC;
        #1;
        chk("rr_s1_second", bus.s1_ready, 1);
        chk("rr_s0_wait", bus.s0_ready, 0);
        chk("rr_w4_we", bus.we, 1);
        chk("rr_w4_addr", bus.waddr, 4);
        chk("rr_w4_data", bus.wdata, 32'hA);
        nxt();
        bus.s1_valid = 1'b0;
        #1;
        chk("rr_s0_third", bus.s0_ready, 1);
        chk("rr_w5_addr", bus.waddr, 5);
        chk("rr_w5_data", bus.wdata, 32'hB);
        nxt();
        bus.s0_valid = 1'b0;
        bus.wstall = 1'b1;
        bus.s1_valid = 1'b1; bus.s1_addr = 5'd7; bus.s1_data = 32'h77;
        #1;
        chk("rr_w6_addr", bus.waddr, 6);
        chk("rr_w6_data", bus.wdata, 32'hC);

        // Write port blocked for three cycles with the slot full.
        for (int i = 0; i < 3; i++) begin
            chk("stall_we", bus.we, 0);
            chk("stall_s1_ready", bus.s1_ready, 0);
            nxt();
            #1;
        end
        bus.wstall = 1'b0;
        #1;
        chk("unstall_we", bus.we, 1);
        chk("unstall_waddr", bus.waddr, 6);
        chk("unstall_s1_ready", bus.s1_ready, 1);
        nxt();
        bus.s1_valid = 1'b0;
        #1;
        chk("w7_we", bus.we, 1);
        chk("w7_addr", bus.waddr, 7);
        chk("w7_data", bus.wdata, 32'h77);
        nxt();

        // Scoreboard: r9 issue, commit with write-through, then clear.
        bus.chk_addr1 = 5'd9; bus.chk_addr2 = 5'd0;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        #1;
        chk("w7_drained", bus.we, 0);
        chk("iss9_legal", bus.busy1, 0);
        nxt();
        bus.iss_valid = 1'b0;
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd9; bus.s0_data = 32'h99;
        #1;
        chk("r9_busy", bus.busy1, 1);
        chk("r0_query", bus.busy2, 0);
        chk("r9_s0_ready", bus.s0_ready, 1);
        nxt();
        bus.s0_valid = 1'b0;
        #1;
        chk("r9_commit_we", bus.we, 1);
        chk("r9_commit_busy", bus.busy1, 0);
        nxt();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        #1;
        chk("r9_cleared", bus.busy1, 0);
        nxt();
        bus.iss_valid = 1'b0;
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd9; bus.s0_data = 32'h9A;
        #1;
        chk("r9b_busy", bus.busy1, 1);
        nxt();
        // Commit of r9 and a new issue to r9 on the same edge.
        bus.s0_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        #1;
        chk("r9b_we", bus.we, 1);
        chk("r9b_waddr", bus.waddr, 9);
        chk("iss9b_legal", bus.busy1, 0);
        nxt();
        bus.iss_valid = 1'b0;
        #1;
        chk("set_wins", bus.busy1, 1);
        bus.flush = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd10; bus.chk_addr2 = 5'd10;
        #1;
        chk("iss10_legal", bus.busy2, 0);
        nxt();
        bus.flush = 1'b0; bus.iss_valid = 1'b0;
        #1;
        chk("flush_r9", bus.busy1, 0);
        chk("flush_r10", bus.busy2, 0);

        // Reset while the slot holds r12 and r13 is busy.
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd12; bus.s0_data = 32'hCC;
        nxt();
        bus.s0_valid = 1'b0; bus.wstall = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd13;
        nxt();
        bus.iss_valid = 1'b0; bus.wstall = 1'b0; bus.chk_addr1 = 5'd13;
        #1;
        chk("pre_rst_we", bus.we, 1);
        chk("pre_rst_waddr", bus.waddr, 12);
        chk("pre_rst_busy", bus.busy1, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", bus.we, 0);
        chk("mid_rst_waddr", bus.waddr, 0);
        chk("mid_rst_busy", bus.busy1, 0);
        nxt();
        rst = 1'b0;
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd14; bus.s0_data = 32'hE;
        bus.s1_valid = 1'b1; bus.s1_addr = 5'd15; bus.s1_data = 32'hF;
        #1;
        chk("post_rst_we", bus.we, 0);
        chk("post_rst_rr_s0", bus.s0_ready, 1);
        chk("post_rst_rr_s1", bus.s1_ready, 0);
        nxt();
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
